instr_fetch_unit: RTL and testbench

//  Initiator side of the instruction-ROM interface: owns the PC, drives imem_addr, captures imem_data.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_buffer.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 87 ++++++++
 tb/tb_instr_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// The JAL target helper is only used when FETCH_JAL_PREDICT_EN is defined.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               pred;
  } fetch_entry_t;

  // J-type immediate: imm[20|10:1|11|19:12] in instr[31:12], bit 0 implied zero
  function automatic logic [XLEN-1:0] jal_target(input logic [XLEN-1:0]    pc,
                                                 input logic [INSTR_W-1:0] instr);
    logic [XLEN-1:0] imm;
    logic            instr_low_unused;
    instr_low_unused = ^instr[11:0];
    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    return pc + imm;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {pc, instr, pred} entries.
// Flush has priority over push and pop; depth must be a power of two.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic            do_push_s;
  logic            do_pop_s;

  assign full      = (count_r == DEPTH[AW:0]);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  // An empty buffer presents an all-zero head so reset and flush look identical downstream
  assign rdata     = empty ? '0 : mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC register, next-PC selection (redirect > JAL predict > +4), fetch buffer.
// Optional static JAL prediction is enabled with macro FETCH_JAL_PREDICT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic        fetch_pred_taken
);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] seq_pc_s;
  logic            pred_s;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            empty_s;
  logic            redirect_lsb_unused_s;
  fetch_entry_t    entry_s;
  fetch_entry_t    head_s;

  assign redirect_lsb_unused_s = ^redirect_pc[1:0];

  assign imem_addr = pc_r;
  assign push_s    = !full_s && !redirect_valid;
  assign pop_s     = fetch_valid && fetch_ready;
  assign entry_s   = '{pc: pc_r, instr: imem_data, pred: pred_s};

  // Sequential next PC for the word being fetched this cycle
  always_comb begin
    pred_s   = 1'b0;
    seq_pc_s = pc_r + 32'd4;
`ifdef FETCH_JAL_PREDICT_EN
    if (imem_data[6:0] == OPC_JAL) begin
      pred_s   = 1'b1;
      seq_pc_s = jal_target(pc_r, imem_data);
    end else begin
      pred_s   = 1'b0;
      seq_pc_s = pc_r + 32'd4;
    end
`endif
  end

  // PC register: reset, then redirect, then advance only when the word was buffered
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= {redirect_pc[31:2], 2'b00};
    end else if (push_s) begin
      pc_r <= seq_pc_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  fetch_buffer #(
    .DEPTH (FB_DEPTH)
  ) u_fetch_buffer (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .wdata (entry_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign fetch_valid      = !empty_s;
  assign fetch_pc         = head_s.pc;
  assign fetch_instr      = head_s.instr;
  assign fetch_pred_taken = head_s.pred;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit; expectations follow FETCH_JAL_PREDICT_EN when defined.
module tb_instr_fetch_unit;

`ifdef FETCH_JAL_PREDICT_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_pred_taken;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom = 32'h0045_0693;
      32'h0000_0004: rom = 32'h0010_0713;
      32'h0000_0008: rom = 32'h00b7_6463;
      32'h0000_001c: rom = 32'h0118_5a63;
      32'h0000_0048: rom = 32'hfc1f_f06f;
      default:       rom = {a[24:0], 7'h13};
    endcase
  endfunction

  assign imem_data = rom(imem_addr);

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .FB_DEPTH (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .fetch_valid      (fetch_valid),
    .fetch_ready      (fetch_ready),
    .fetch_instr      (fetch_instr),
    .fetch_pc         (fetch_pc),
    .fetch_pred_taken (fetch_pred_taken)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
    exp_t e;
    e.pc = pc; e.instr = instr; e.pred = pred;
    sb_q.push_back(e);
  endtask

  // Waits up to budget sample points for a handshake and returns what was transferred
  task automatic take(input int budget, output bit got, output logic [31:0] pc,
                      output logic [31:0] instr, output logic pred);
    got = 1'b0; pc = 32'h0; instr = 32'h0; pred = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fetch_valid === 1'b1 && fetch_ready === 1'b1) begin
        got = 1'b1; pc = fetch_pc; instr = fetch_instr; pred = fetch_pred_taken;
        tick();
        return;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; fetch_ready = 1'b0;
    tick();
    tick();
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fetch_valid); end
    checks++; if (fetch_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", fetch_instr); end
    checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", fetch_pc); end
    checks++; if (fetch_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b want 0", fetch_pred_taken); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_stream();
    bit got; logic [31:0] pc, ins; logic pr; exp_t e;
    fetch_ready = 1'b1;
    rst = 1'b0;
    sb_q.delete();
    expect_entry(32'h0, 32'h0045_0693, 1'b0);
    expect_entry(32'h4, 32'h0010_0713, 1'b0);
    expect_entry(32'h8, 32'h00b7_6463, 1'b0);
    for (int k = 0; k < 3; k++) begin
      e = sb_q.pop_front();
      take((k == 0) ? 2 : 1, got, pc, ins, pr);
      checks++;
      if (!got || pc !== e.pc || ins !== e.instr || pr !== e.pred) begin
        errors++;
        $display("FAIL stream[%0d]: got=%0b pc=%h instr=%h pred=%b, want pc=%h instr=%h pred=%b",
                 k, got, pc, ins, pr, e.pc, e.instr, e.pred);
      end
    end
  endtask

  task automatic test_backpressure();
    fetch_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0 || fetch_instr !== 32'h0045_0693) begin
        errors++;
        $display("FAIL hold_head[%0d]: valid=%b pc=%h instr=%h, want 1 0 00450693",
                 i, fetch_valid, fetch_pc, fetch_instr);
      end
    end
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL full_imem_addr: got %h want 8", imem_addr); end
  endtask

  task automatic test_redirect();
    bit got; logic [31:0] pc, ins; logic pr; exp_t e;
    fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_001c;
    sb_q.delete();
    expect_entry(32'h1c, 32'h0118_5a63, 1'b0);
    expect_entry(32'h20, rom(32'h20), 1'b0);
    tick();
    redirect_valid = 1'b0;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL redirect_gap: valid=%b pc=%h want valid 0", fetch_valid, fetch_pc); end
    checks++; if (imem_addr !== 32'h1c) begin errors++; $display("FAIL redirect_addr: got %h want 1c", imem_addr); end
    tick();
    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front();
      take(1, got, pc, ins, pr);
      checks++;
      if (!got || pc !== e.pc || ins !== e.instr || pr !== e.pred) begin
        errors++;
        $display("FAIL redirect[%0d]: got=%0b pc=%h instr=%h pred=%b, want pc=%h instr=%h pred=%b",
                 k, got, pc, ins, pr, e.pc, e.instr, e.pred);
      end
    end
  endtask

  task automatic test_align();
    bit got; logic [31:0] pc, ins; logic pr; exp_t e;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_001e;
    sb_q.delete();
    expect_entry(32'h1c, 32'h0118_5a63, 1'b0);
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'h1c) begin errors++; $display("FAIL align_addr: got %h want 1c", imem_addr); end
    tick();
    e = sb_q.pop_front();
    take(1, got, pc, ins, pr);
    checks++;
    if (!got || pc !== e.pc || ins !== e.instr) begin
      errors++;
      $display("FAIL align: got=%0b pc=%h instr=%h, want pc=%h instr=%h", got, pc, ins, e.pc, e.instr);
    end
  endtask

  task automatic test_wrap();
    bit got; logic [31:0] pc, ins; logic pr; exp_t e;
    redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
    sb_q.delete();
    expect_entry(32'hffff_fffc, rom(32'hffff_fffc), 1'b0);
    expect_entry(32'h0, 32'h0045_0693, 1'b0);
    tick();
    redirect_valid = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front();
      take(1, got, pc, ins, pr);
      checks++;
      if (!got || pc !== e.pc || ins !== e.instr || pr !== e.pred) begin
        errors++;
        $display("FAIL wrap[%0d]: got=%0b pc=%h instr=%h, want pc=%h instr=%h", k, got, pc, ins, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_jal();
    bit got; logic [31:0] pc, ins; logic pr; exp_t e;
    logic [31:0] tgt;
    tgt = PRED_EN ? 32'h08 : 32'h4c;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0048;
    sb_q.delete();
    expect_entry(32'h48, 32'hfc1f_f06f, PRED_EN);
    expect_entry(tgt, rom(tgt), 1'b0);
    tick();
    redirect_valid = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front();
      take(1, got, pc, ins, pr);
      checks++;
      if (!got || pc !== e.pc || ins !== e.instr || pr !== e.pred) begin
        errors++;
        $display("FAIL jal[%0d]: got=%0b pc=%h instr=%h pred=%b, want pc=%h instr=%h pred=%b",
                 k, got, pc, ins, pr, e.pc, e.instr, e.pred);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit got; logic [31:0] pc, ins; logic pr; exp_t e;
    fetch_ready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", fetch_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_addr: got %h want 0", imem_addr); end
    checks++; if (fetch_pc !== 32'h0 || fetch_instr !== 32'h0) begin
      errors++; $display("FAIL midrst_head: pc=%h instr=%h want 0 0", fetch_pc, fetch_instr);
    end
    rst = 1'b0; redirect_valid = 1'b0; fetch_ready = 1'b1;
    sb_q.delete();
    expect_entry(32'h0, 32'h0045_0693, 1'b0);
    expect_entry(32'h4, 32'h0010_0713, 1'b0);
    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front();
      take((k == 0) ? 2 : 1, got, pc, ins, pr);
      checks++;
      if (!got || pc !== e.pc || ins !== e.instr || pr !== e.pred) begin
        errors++;
        $display("FAIL midrst[%0d]: got=%0b pc=%h instr=%h, want pc=%h instr=%h", k, got, pc, ins, e.pc, e.instr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_align();
    test_wrap();
    test_jal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
